// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: takes a PC from the fetch stage, runs one req/ack read on the
// instruction bus, and hands the word (or a NOP with a fault code) to decode.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core_N,
  input  logic        Fetch_Valid,
  input  logic [31:0] Fetch_Addr,
  output logic        Fetch_Ready,
  input  logic        Flush,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Rdata,
  input  logic        Mem_Err,
  output logic        Instr_Valid,
  output logic [31:0] Instr,
  output logic [31:0] Instr_Addr,
  output logic [1:0]  Instr_Fault,
  input  logic        Instr_Ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_ALIGN = 2'b01;
  localparam logic [1:0] FLT_BUS   = 2'b10;
  localparam logic [1:0] FLT_TMO   = 2'b11;
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        instr_vld_q;
  logic [31:0] instr_q;
  logic [31:0] instr_addr_q;
  logic [1:0]  instr_flt_q;

  // Only the acceptance handshake is combinational so the PC stage sees a redirect at once.
  assign Fetch_Ready = (state_q == IDLE) && !Flush;

  assign Mem_Req     = mem_req_q;
  assign Mem_Addr    = mem_addr_q;
  assign Instr_Valid = instr_vld_q;
  assign Instr       = instr_q;
  assign Instr_Addr  = instr_addr_q;
  assign Instr_Fault = instr_flt_q;

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      instr_vld_q  <= 1'b0;
      instr_q      <= 32'd0;
      instr_addr_q <= 32'd0;
      instr_flt_q  <= FLT_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Fetch_Valid && !Flush) begin
            instr_addr_q <= Fetch_Addr;
            if (Fetch_Addr[1:0] != 2'b00) begin
              instr_q     <= NOP_INSTR;
              instr_flt_q <= FLT_ALIGN;
              instr_vld_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= {Fetch_Addr[31:2], 2'b00};
              cnt_q      <= 8'd0;
              state_q    <= BUS;
            end
          end
        end

        BUS: begin
          if (Flush) begin
            if (Mem_Ack) begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              // Request must stay up until the bus answers; DRAIN swallows the reply.
              if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 8'd1;
              state_q <= DRAIN;
            end
          end else if (Mem_Ack) begin
            instr_q     <= Mem_Err ? NOP_INSTR : Mem_Rdata;
            instr_flt_q <= Mem_Err ? FLT_BUS : FLT_NONE;
            instr_vld_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            instr_q     <= NOP_INSTR;
            instr_flt_q <= FLT_TMO;
            instr_vld_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        DRAIN: begin
          if (Mem_Ack || (cnt_q >= CNT_LAST)) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        RESP: begin
          if (Flush || Instr_Ready) begin
            instr_vld_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus a hand-written
// asynchronous-reset sequence.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic [1:0]  instr_fault;
  logic        instr_ready;

  int checks;
  int failures;

  instr_fetch_unit #(
    .TIMEOUT_CYCLES(4),
    .NOP_INSTR     (32'h00000013)
  ) dut (
    .Clk_Core    (clk),
    .Rst_Core_N  (rst_n),
    .Fetch_Valid (fetch_valid),
    .Fetch_Addr  (fetch_addr),
    .Fetch_Ready (fetch_ready),
    .Flush       (flush),
    .Mem_Req     (mem_req),
    .Mem_Addr    (mem_addr),
    .Mem_Ack     (mem_ack),
    .Mem_Rdata   (mem_rdata),
    .Mem_Err     (mem_err),
    .Instr_Valid (instr_valid),
    .Instr       (instr),
    .Instr_Addr  (instr_addr),
    .Instr_Fault (instr_fault),
    .Instr_Ready (instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fv;
    logic [31:0] fa;
    logic        fl;
    logic        ack;
    logic [31:0] rd;
    logic        err;
    logic        ir;
    logic        e_fr;
    logic        e_req;
    logic [31:0] e_ma;
    logic        e_iv;
    logic [31:0] e_ins;
    logic [31:0] e_ia;
    logic [1:0]  e_flt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic fv_, logic [31:0] fa_, logic fl_, logic ack_,
                             logic [31:0] rd_, logic err_, logic ir_, logic fr_,
                             logic req_, logic [31:0] ma_, logic iv_, logic [31:0] ins_,
                             logic [31:0] ia_, logic [1:0] flt_);
    vec_t r;
    r.fv = fv_;   r.fa = fa_;   r.fl = fl_;     r.ack = ack_;  r.rd = rd_;
    r.err = err_; r.ir = ir_;   r.e_fr = fr_;   r.e_req = req_; r.e_ma = ma_;
    r.e_iv = iv_; r.e_ins = ins_; r.e_ia = ia_; r.e_flt = flt_;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    fetch_valid = r.fv;
    fetch_addr  = r.fa;
    flush       = r.fl;
    mem_ack     = r.ack;
    mem_rdata   = r.rd;
    mem_err     = r.err;
    instr_ready = r.ir;
  endtask

  task automatic idle_inputs();
    fetch_valid = 1'b0;
    fetch_addr  = 32'd0;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'd0;
    mem_err     = 1'b0;
    instr_ready = 1'b0;
  endtask

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I1  = 32'h00500093;
  localparam logic [31:0] I2  = 32'h12345678;
  localparam logic [31:0] I3  = 32'h11111111;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();

    //          fv fa            fl ack rd             err ir  fr req ma        iv ins            ia        flt
    // zero-wait fetch of 0x0
    vq.push_back(v(1, 32'h0,     0, 0, 32'h0,         0, 0,  1, 0, 32'h0,   0, 32'h0,        32'h0,   0));
    vq.push_back(v(0, 32'h0,     0, 1, I1,            0, 0,  0, 1, 32'h0,   0, 32'h0,        32'h0,   0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 1,  0, 0, 32'h0,   1, I1,           32'h0,   0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  1, 0, 32'h0,   0, I1,           32'h0,   0));
    // 0x104 with 3 wait states (ack lands on the last counter value), decode stalls 2 cycles
    vq.push_back(v(1, 32'h104,   0, 0, 32'h0,         0, 0,  1, 0, 32'h0,   0, I1,           32'h0,   0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  0, 1, 32'h104, 0, I1,           32'h104, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  0, 1, 32'h104, 0, I1,           32'h104, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  0, 1, 32'h104, 0, I1,           32'h104, 0));
    vq.push_back(v(0, 32'h0,     0, 1, I2,            0, 0,  0, 1, 32'h104, 0, I1,           32'h104, 0));
    vq.push_back(v(0, 32'h0,     0, 1, 32'hCAFEF00D,  0, 0,  0, 0, 32'h104, 1, I2,           32'h104, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  0, 0, 32'h104, 1, I2,           32'h104, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 1,  0, 0, 32'h104, 1, I2,           32'h104, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  1, 0, 32'h104, 0, I2,           32'h104, 0));
    // misaligned 0x102: no bus request
    vq.push_back(v(1, 32'h102,   0, 0, 32'h0,         0, 0,  1, 0, 32'h104, 0, I2,           32'h104, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 1,  0, 0, 32'h104, 1, NOP,          32'h102, 1));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  1, 0, 32'h104, 0, NOP,          32'h102, 1));
    // bus error
    vq.push_back(v(1, 32'h300,   0, 0, 32'h0,         0, 0,  1, 0, 32'h104, 0, NOP,          32'h102, 1));
    vq.push_back(v(0, 32'h0,     0, 1, 32'hAAAAAAAA,  1, 0,  0, 1, 32'h300, 0, NOP,          32'h300, 1));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 1,  0, 0, 32'h300, 1, NOP,          32'h300, 2));
    // timeout after 4 request cycles
    vq.push_back(v(1, 32'h400,   0, 0, 32'h0,         0, 0,  1, 0, 32'h300, 0, NOP,          32'h300, 2));
    for (int k = 0; k < 4; k++)
      vq.push_back(v(0, 32'h0,   0, 0, 32'h0,         0, 0,  0, 1, 32'h400, 0, NOP,          32'h400, 2));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  0, 0, 32'h400, 1, NOP,          32'h400, 3));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 1,  0, 0, 32'h400, 1, NOP,          32'h400, 3));
    // flush one cycle into BUS, ack two cycles later is discarded
    vq.push_back(v(1, 32'h500,   0, 0, 32'h0,         0, 0,  1, 0, 32'h400, 0, NOP,          32'h400, 3));
    vq.push_back(v(0, 32'h0,     1, 0, 32'h0,         0, 0,  0, 1, 32'h500, 0, NOP,          32'h500, 3));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  0, 1, 32'h500, 0, NOP,          32'h500, 3));
    vq.push_back(v(0, 32'h0,     0, 1, 32'hDEADBEEF,  0, 0,  0, 1, 32'h500, 0, NOP,          32'h500, 3));
    // next fetch 0x200 returns normally
    vq.push_back(v(1, 32'h200,   0, 0, 32'h0,         0, 0,  1, 0, 32'h500, 0, NOP,          32'h500, 3));
    vq.push_back(v(0, 32'h0,     0, 1, 32'h00000513,  0, 0,  0, 1, 32'h200, 0, NOP,          32'h200, 3));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 1,  0, 0, 32'h200, 1, 32'h513,      32'h200, 0));
    // flush in IDLE blocks acceptance; flush in RESP beats Instr_Ready
    vq.push_back(v(1, 32'h600,   1, 0, 32'h0,         0, 0,  0, 0, 32'h200, 0, 32'h513,      32'h200, 0));
    vq.push_back(v(1, 32'h600,   0, 0, 32'h0,         0, 0,  1, 0, 32'h200, 0, 32'h513,      32'h200, 0));
    vq.push_back(v(0, 32'h0,     0, 1, I3,            0, 0,  0, 1, 32'h600, 0, 32'h513,      32'h600, 0));
    vq.push_back(v(0, 32'h0,     1, 0, 32'h0,         0, 1,  0, 0, 32'h600, 1, I3,           32'h600, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  1, 0, 32'h600, 0, I3,           32'h600, 0));
    // flush together with ack in BUS
    vq.push_back(v(1, 32'h700,   0, 0, 32'h0,         0, 0,  1, 0, 32'h600, 0, I3,           32'h600, 0));
    vq.push_back(v(0, 32'h0,     1, 1, 32'h22222222,  0, 0,  0, 1, 32'h700, 0, I3,           32'h700, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  1, 0, 32'h700, 0, I3,           32'h700, 0));
    // flush then no ack: DRAIN ends on timeout, no response
    vq.push_back(v(1, 32'h900,   0, 0, 32'h0,         0, 0,  1, 0, 32'h700, 0, I3,           32'h700, 0));
    vq.push_back(v(0, 32'h0,     1, 0, 32'h0,         0, 0,  0, 1, 32'h900, 0, I3,           32'h900, 0));
    for (int k = 0; k < 3; k++)
      vq.push_back(v(0, 32'h0,   0, 0, 32'h0,         0, 0,  0, 1, 32'h900, 0, I3,           32'h900, 0));
    vq.push_back(v(0, 32'h0,     0, 0, 32'h0,         0, 0,  1, 0, 32'h900, 0, I3,           32'h900, 0));

    // reset state
    #12;
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_mem_req",     32'(mem_req),     32'd0);
    chk("rst_mem_addr",    mem_addr,         32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr",       instr,            32'd0);
    chk("rst_instr_addr",  instr_addr,       32'd0);
    chk("rst_instr_fault", 32'(instr_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #2;
      chk($sformatf("v%0d_fetch_ready", i), 32'(fetch_ready), 32'(vq[i].e_fr));
      chk($sformatf("v%0d_mem_req", i),     32'(mem_req),     32'(vq[i].e_req));
      chk($sformatf("v%0d_mem_addr", i),    mem_addr,         vq[i].e_ma);
      chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vq[i].e_iv));
      chk($sformatf("v%0d_instr", i),       instr,            vq[i].e_ins);
      chk($sformatf("v%0d_instr_addr", i),  instr_addr,       vq[i].e_ia);
      chk($sformatf("v%0d_instr_fault", i), 32'(instr_fault), 32'(vq[i].e_flt));
    end

    // leave a fault code behind, then reset asynchronously in the middle of a bus request
    @(negedge clk);
    idle_inputs();
    fetch_valid = 1'b1;
    fetch_addr  = 32'hA02;
    @(negedge clk);
    idle_inputs();
    instr_ready = 1'b1;
    #2;
    chk("seq_align_fault", 32'(instr_fault), 32'd1);
    @(negedge clk);
    idle_inputs();
    fetch_valid = 1'b1;
    fetch_addr  = 32'hA00;
    @(negedge clk);
    idle_inputs();
    #2;
    chk("seq_bus_req", 32'(mem_req), 32'd1);
    chk("seq_bus_addr", mem_addr, 32'hA00);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_mem_req",     32'(mem_req),     32'd0);
    chk("async_instr_valid", 32'(instr_valid), 32'd0);
    chk("async_instr_fault", 32'(instr_fault), 32'd0);
    chk("async_mem_addr",    mem_addr,         32'd0);
    chk("async_instr_addr",  instr_addr,       32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_fetch_ready", 32'(fetch_ready), 32'd1);

    // normal fetch after reset release
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_addr  = 32'hB00;
    @(negedge clk);
    idle_inputs();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000A0B3;
    #2;
    chk("post_rst_req",  32'(mem_req), 32'd1);
    chk("post_rst_addr", mem_addr,     32'hB00);
    @(negedge clk);
    idle_inputs();
    instr_ready = 1'b1;
    #2;
    chk("post_rst_valid", 32'(instr_valid), 32'd1);
    chk("post_rst_instr", instr,            32'h0000A0B3);
    chk("post_rst_iaddr", instr_addr,       32'hB00);
    chk("post_rst_fault", 32'(instr_fault), 32'd0);
    @(negedge clk);
    idle_inputs();
    #2;
    chk("post_rst_idle", 32'(fetch_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
